// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch: resolves BEQ/BNE, raises overflow traps, emits a
// one-cycle fetch redirect and freezes on HALT until reset.
module ex_mem_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_flush,
  input  logic [31:0] alu_O,
  input  logic        alu_Z,
  input  logic        alu_N,
  input  logic        alu_V,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [1:0]  ex_br_type,
  input  logic        ex_ovf_trap,
  input  logic [31:0] ex_rdata2,
  input  logic [4:0]  ex_wsel,
  input  logic        ex_regwen,
  input  logic        ex_memren,
  input  logic        ex_memwen,
  input  logic        ex_halt,
  output logic        mem_valid,
  output logic [31:0] mem_aluout,
  output logic [31:0] mem_storedata,
  output logic [4:0]  mem_wsel,
  output logic        mem_regwen,
  output logic        mem_memren,
  output logic        mem_memwen,
  output logic        mem_halt,
  output logic        mem_exc,
  output logic [31:0] mem_epc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic        capture;
  logic        trap;
  logic        taken;
  logic [31:0] br_target;
  logic        unused_flags;

  // The negative flag carries no meaning for this stage.
  assign unused_flags = alu_N;

  assign capture   = ex_valid & ~ex_stall & ~ex_flush & (state == RUN);
  assign trap      = ex_ovf_trap & alu_V;
  assign taken     = ((ex_br_type == 2'b01) & alu_Z) | ((ex_br_type == 2'b10) & ~alu_Z);
  assign br_target = ex_pc + 32'd4 + {ex_imm[29:0], 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= RUN;
      mem_valid      <= 1'b0;
      mem_aluout     <= '0;
      mem_storedata  <= '0;
      mem_wsel       <= '0;
      mem_regwen     <= 1'b0;
      mem_memren     <= 1'b0;
      mem_memwen     <= 1'b0;
      mem_halt       <= 1'b0;
      mem_exc        <= 1'b0;
      mem_epc        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (capture) begin
        mem_valid     <= 1'b1;
        mem_aluout    <= alu_O;
        mem_storedata <= ex_rdata2;
        mem_wsel      <= ex_wsel;
        mem_regwen    <= ex_regwen & ~trap;
        mem_memren    <= ex_memren & ~trap;
        mem_memwen    <= ex_memwen & ~trap;
        mem_halt      <= ex_halt;
        mem_exc       <= trap;
        mem_epc       <= trap ? ex_pc : 32'd0;
        if (ex_halt) begin
          state <= HALTED;
        end
        if (trap | taken) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= trap ? EXC_VECTOR : br_target;
        end
      end else if ((state == RUN) && (!ex_stall || ex_flush)) begin
        // Flush overrides stall; HALTED keeps the halt instruction latched.
        mem_valid     <= 1'b0;
        mem_aluout    <= '0;
        mem_storedata <= '0;
        mem_wsel      <= '0;
        mem_regwen    <= 1'b0;
        mem_memren    <= 1'b0;
        mem_memwen    <= 1'b0;
        mem_halt      <= 1'b0;
        mem_exc       <= 1'b0;
        mem_epc       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed literal checks followed by random traffic
// compared every cycle against a behavioural model of the latch.
module tb_ex_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ex_valid, ex_stall, ex_flush;
  logic [31:0] alu_O;
  logic        alu_Z, alu_N, alu_V;
  logic [31:0] ex_pc, ex_imm, ex_rdata2;
  logic [1:0]  ex_br_type;
  logic        ex_ovf_trap;
  logic [4:0]  ex_wsel;
  logic        ex_regwen, ex_memren, ex_memwen, ex_halt;
  logic        mem_valid, mem_regwen, mem_memren, mem_memwen, mem_halt, mem_exc;
  logic [31:0] mem_aluout, mem_storedata, mem_epc, redirect_pc;
  logic [4:0]  mem_wsel;
  logic        redirect_valid;

  typedef struct packed {
    logic        valid;
    logic [31:0] aluout;
    logic [31:0] storedata;
    logic [4:0]  wsel;
    logic        regwen;
    logic        memren;
    logic        memwen;
    logic        halt;
    logic        exc;
    logic [31:0] epc;
    logic        rv;
    logic [31:0] rpc;
  } outs_t;

  outs_t m;
  logic  halted;
  logic  model_ready = 1'b0;
  int    compared = 0;
  int    mismatched = 0;

  ex_mem_stage #(.EXC_VECTOR(32'h0000_0080)) dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .alu_O(alu_O), .alu_Z(alu_Z), .alu_N(alu_N), .alu_V(alu_V),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_br_type(ex_br_type),
    .ex_ovf_trap(ex_ovf_trap), .ex_rdata2(ex_rdata2), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_memren(ex_memren), .ex_memwen(ex_memwen),
    .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_aluout(mem_aluout), .mem_storedata(mem_storedata),
    .mem_wsel(mem_wsel), .mem_regwen(mem_regwen), .mem_memren(mem_memren),
    .mem_memwen(mem_memwen), .mem_halt(mem_halt), .mem_exc(mem_exc),
    .mem_epc(mem_epc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the EX/MEM latch must hold after each edge.
  always @(posedge CLK) begin
    logic        is_trap, is_taken;
    logic [31:0] keep_rpc;
    if (RST) begin
      m = '0;
      halted = 1'b0;
      model_ready = 1'b1;
    end else begin
      m.rv = 1'b0;
      if (halted) begin
      end else if (ex_valid && !ex_stall && !ex_flush) begin
        is_trap  = ex_ovf_trap && alu_V;
        is_taken = (ex_br_type == 2'd1 && alu_Z) || (ex_br_type == 2'd2 && !alu_Z);
        m.valid     = 1'b1;
        m.aluout    = alu_O;
        m.storedata = ex_rdata2;
        m.wsel      = ex_wsel;
        m.regwen    = ex_regwen && !is_trap;
        m.memren    = ex_memren && !is_trap;
        m.memwen    = ex_memwen && !is_trap;
        m.halt      = ex_halt;
        m.exc       = is_trap;
        m.epc       = is_trap ? ex_pc : 32'd0;
        if (is_trap) begin
          m.rv  = 1'b1;
          m.rpc = 32'h0000_0080;
        end else if (is_taken) begin
          m.rv  = 1'b1;
          m.rpc = ex_pc + 32'd4 + ex_imm * 32'd4;
        end
        if (ex_halt) halted = 1'b1;
      end else if (ex_stall && !ex_flush) begin
      end else begin
        keep_rpc = m.rpc;
        m = '0;
        m.rpc = keep_rpc;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_ready) begin
      checkOutput("mem_valid", 32'(mem_valid), 32'(m.valid));
      checkOutput("mem_aluout", mem_aluout, m.aluout);
      checkOutput("mem_storedata", mem_storedata, m.storedata);
      checkOutput("mem_wsel", 32'(mem_wsel), 32'(m.wsel));
      checkOutput("mem_regwen", 32'(mem_regwen), 32'(m.regwen));
      checkOutput("mem_memren", 32'(mem_memren), 32'(m.memren));
      checkOutput("mem_memwen", 32'(mem_memwen), 32'(m.memwen));
      checkOutput("mem_halt", 32'(mem_halt), 32'(m.halt));
      checkOutput("mem_exc", 32'(mem_exc), 32'(m.exc));
      checkOutput("mem_epc", mem_epc, m.epc);
      checkOutput("redirect_valid", 32'(redirect_valid), 32'(m.rv));
      checkOutput("redirect_pc", redirect_pc, m.rpc);
    end
  end

  task automatic applyStimulus(input logic valid, input logic stall, input logic flush,
                               input logic [1:0] br, input logic z, input logic v,
                               input logic trap, input logic halt,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] o);
    ex_valid    = valid;
    ex_stall    = stall;
    ex_flush    = flush;
    ex_br_type  = br;
    alu_Z       = z;
    alu_N       = o[31];
    alu_V       = v;
    ex_ovf_trap = trap;
    ex_halt     = halt;
    ex_pc       = pc;
    ex_imm      = imm;
    alu_O       = o;
    ex_rdata2   = o ^ 32'h5A5A_5A5A;
    ex_wsel     = pc[6:2];
    ex_regwen   = 1'b1;
    ex_memren   = 1'b0;
    ex_memwen   = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    RST = 1'b1;
    tick();
    checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset mem_epc", mem_epc, 32'd0);
    RST = 1'b0;

    // Trapping ADD at 0x40.
    applyStimulus(1, 0, 0, 2'd0, 0, 1, 1, 0, 32'h40, 32'h0, 32'h8000_0000);
    tick();
    checkOutput("trap mem_exc", 32'(mem_exc), 32'd1);
    checkOutput("trap mem_epc", mem_epc, 32'h40);
    checkOutput("trap mem_regwen", 32'(mem_regwen), 32'd0);
    checkOutput("trap redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("trap redirect_pc", redirect_pc, 32'h80);
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 0, 0, 32'h44, 32'h0, 32'h0);
    tick();
    checkOutput("trap pulse end", 32'(redirect_valid), 32'd0);
    checkOutput("trap rpc hold", redirect_pc, 32'h80);

    // BEQ backward, then not taken.
    applyStimulus(1, 0, 0, 2'd1, 1, 0, 0, 0, 32'h100, 32'hFFFF_FFFE, 32'h0);
    tick();
    checkOutput("beq redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("beq redirect_pc", redirect_pc, 32'hFC);
    applyStimulus(1, 0, 0, 2'd1, 0, 0, 0, 0, 32'h100, 32'hFFFF_FFFE, 32'h1);
    tick();
    checkOutput("beq not taken", 32'(redirect_valid), 32'd0);
    checkOutput("beq rpc hold", redirect_pc, 32'hFC);

    // BNE wrapping past 2^32.
    applyStimulus(1, 0, 0, 2'd2, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h4, 32'h3);
    tick();
    checkOutput("bne wrap valid", 32'(redirect_valid), 32'd1);
    checkOutput("bne wrap pc", redirect_pc, 32'h0000_000C);

    // Captured taken branch, then three stalled cycles.
    applyStimulus(1, 0, 0, 2'd1, 1, 0, 0, 0, 32'h200, 32'h10, 32'hDEAD_BEEF);
    tick();
    checkOutput("stall pre aluout", mem_aluout, 32'hDEAD_BEEF);
    checkOutput("stall pre redirect", 32'(redirect_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 2'd1, 1, 1, 1, 0, $urandom, $urandom, $urandom);
      tick();
      checkOutput("stall hold aluout", mem_aluout, 32'hDEAD_BEEF);
      checkOutput("stall no redirect", 32'(redirect_valid), 32'd0);
    end
    applyStimulus(1, 1, 1, 2'd0, 0, 0, 0, 0, 32'h300, 32'h0, 32'h7);
    tick();
    checkOutput("stall+flush valid", 32'(mem_valid), 32'd0);

    // Flush beats an otherwise taken branch.
    applyStimulus(1, 0, 1, 2'd1, 1, 0, 0, 0, 32'h400, 32'h8, 32'h9);
    tick();
    checkOutput("flush valid", 32'(mem_valid), 32'd0);
    checkOutput("flush redirect", 32'(redirect_valid), 32'd0);

    // Bubble after a store-capable instruction.
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h500, 32'h0, 32'h11);
    tick();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 0, 0, 32'h504, 32'h0, 32'h12);
    tick();
    checkOutput("bubble valid", 32'(mem_valid), 32'd0);
    checkOutput("bubble regwen", 32'(mem_regwen), 32'd0);
    checkOutput("bubble memwen", 32'(mem_memwen), 32'd0);

    // Halt freezes the latch until reset.
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 0, 1, 32'h600, 32'h0, 32'h1234);
    tick();
    checkOutput("halt captured", 32'(mem_halt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 2'd1, 1, 0, 0, 0, $urandom, $urandom, $urandom);
      tick();
      checkOutput("halted mem_halt", 32'(mem_halt), 32'd1);
      checkOutput("halted aluout", mem_aluout, 32'h1234);
      checkOutput("halted redirect", 32'(redirect_valid), 32'd0);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("halt reset valid", 32'(mem_valid), 32'd0);
    checkOutput("halt reset mem_halt", 32'(mem_halt), 32'd0);
    checkOutput("halt reset rpc", redirect_pc, 32'd0);
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h700, 32'h0, 32'h55);
    tick();
    checkOutput("post reset valid", 32'(mem_valid), 32'd1);
    checkOutput("post reset aluout", mem_aluout, 32'h55);

    // Random traffic, with occasional resets to leave the halted state.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0),
                    $urandom, $urandom, $urandom);
      ex_wsel   = 5'($urandom_range(0, 31));
      ex_regwen = 1'($urandom_range(0, 1));
      ex_memren = 1'($urandom_range(0, 1));
      ex_memwen = 1'($urandom_range(0, 1));
      RST       = ($urandom_range(0, 49) == 0);
      tick();
    end
    RST = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
